double_pack: RTL and testbench
==============================

// Module: double_pack
// PURPOSE
//  Iterative normalise/round/pack unit: turns an unpacked double (sign, unbiased exponent,
//  mantissa with guard/round/sticky bits) into an IEEE-754 64-bit word. It is the inverse of
//  the unpack front-end used by the double comparators (debias, implicit-bit restore) and is
//  the common back-end for the arithmetic cores. Operands use a valid/ready handshake on both sides.
// PARAMETERS
//  EXP_W   11    exponent field width
//  MAN_W   52    stored fraction width
//  BIAS    1023  exponent bias; EMIN = 1-BIAS = -1022, EMAX = BIAS = 1023
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  in_valid     in   1          operand present
//  in_ready     out  1          unit idle, operand accepted when in_valid & in_ready
//  in_s         in   1          sign
//  in_e         in   EXP_W+2    signed unbiased exponent (two's complement)
//  in_m         in   MAN_W+4    [MAN_W+3] integer bit, [MAN_W+2:3] fraction, [2] G, [1] R, [0] sticky
//  out_valid    out  1          result present
//  out_ready    in   1          consumer takes result when out_valid & out_ready
//  out_z        out  EXP_W+MAN_W+1  packed IEEE-754 result
// BEHAVIOUR
//  Value represented: (-1)^s * in_m * 2^(in_e - (MAN_W+3)).
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_z=0. Reset mid-operation aborts; the operand is lost.
//  FSM:
//   IDLE : in_ready=1. On accept, register s,e,m. m==0 -> PACK. Else e<EMIN -> DENORM; else NORM.
//   NORM : per cycle: if m[MSB]==0 and e>EMIN, then m<<=1 and e-=1; else go to ROUND.
//   DENORM: per cycle: m>>=1 with bit0 |= shifted-out bit (sticky), e+=1; e==EMIN -> ROUND.
//          Shifting stops after MAN_W+4 cycles (m becomes sticky only), e forced to EMIN.
//   ROUND: round-to-nearest-even: up = G & (R | S | lsb). Add up to m[MSB:3].
//          Carry out -> m>>=1, e+=1. One cycle.
//   PACK : exp field = e+BIAS if m[MSB]==1, else 0 (subnormal/zero).
//          e>EMAX -> {s, all-ones exp, 0} (infinity). m==0 -> {s, 0} (signed zero).
//          Register out_z, out_valid=1 -> HOLD.
//   HOLD : out_z stable while out_valid & ~out_ready. On handshake: out_valid=0 -> IDLE.
//          No new operand is accepted in the same cycle; in_ready rises the next cycle.
//  Latency accept->out_valid: 3 cycles + shift count (0..MAN_W+4). Throughput: one result in flight.
//  Inputs with NaN encodings are not produced here; the caller packs NaN directly.
//  in_ready=0 in every state except IDLE. in_valid while busy is ignored, not queued.
// TESTING
//  1) s=0,e=0,m=56'h80000000000000 -> out_z=64'h3FF0000000000000 after 3 cycles.
//  2) s=1,e=52,m=56'h00000000000008 -> 52 NORM cycles, out_z=64'hBFF0000000000000.
//  3) Tie: e=0,m=56'h80000000000004 -> 3FF0000000000000 (even stays);
//     m=56'h8000000000000C -> 3FF0000000000002 (odd rounds up).
//  4) e=1023,m=56'hFFFFFFFFFFFFFC -> round carry -> 64'h7FF0000000000000; e=1024,m=56'h80..0 -> infinity.
//  5) e=-1023,m=56'h80000000000000 -> 64'h0008000000000000; m=0,s=1 -> 64'h8000000000000000.
//  6) Hold out_ready=0 for 10 cycles: out_z stable, in_ready=0, extra in_valid ignored.
//     Assert rst mid-NORM: in_ready=1, out_valid=0 immediately.

Source files
------------

// File: rtl/double_pack_if.sv
// Operand/result handshake bundle for the double_pack normalise/round/pack unit.
interface double_pack_if #(
    parameter int unsigned EXP_W = 11,
    parameter int unsigned MAN_W = 52
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_s;
    logic [EXP_W+1:0]         in_e;
    logic [MAN_W+3:0]         in_m;
    logic                     out_valid;
    logic                     out_ready;
    logic [EXP_W+MAN_W:0]     out_z;

    modport master (
        output in_valid, in_s, in_e, in_m, out_ready,
        input  in_ready, out_valid, out_z
    );

    modport slave (
        input  in_valid, in_s, in_e, in_m, out_ready,
        output in_ready, out_valid, out_z
    );
endinterface

// File: rtl/double_pack.sv
// Iterative normalise/round/pack: unpacked (sign, unbiased exponent, mantissa+GRS)
// to an IEEE-754 word, one bit of shift per cycle, one operand in flight.
module double_pack #(
    parameter int unsigned EXP_W = 11,
    parameter int unsigned MAN_W = 52,
    parameter int unsigned BIAS  = 1023
) (
    input  logic          clk,
    input  logic          rst,
    double_pack_if.slave  bus
);
    // One spare exponent bit so a rounding carry on the largest input cannot wrap.
    localparam int unsigned EW = EXP_W + 3;
    localparam int unsigned MW = MAN_W + 4;
    localparam int unsigned ZW = EXP_W + MAN_W + 1;
    localparam int unsigned CW = $clog2(MW + 1);

    localparam logic signed [EW-1:0] EMIN      = EW'(1 - int'(BIAS));
    localparam logic signed [EW-1:0] EMAX      = EW'(int'(BIAS));
    localparam logic signed [EW-1:0] E_ONE     = EW'(1);
    localparam logic [CW-1:0]        SHIFT_MAX = CW'(MW);

    typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, PACK, HOLD} state_t;

    state_t                 state_q, state_n;
    logic                   s_q, s_n;
    logic signed [EW-1:0]   e_q, e_n;
    logic [MW-1:0]          m_q, m_n;
    logic [CW-1:0]          cnt_q, cnt_n;
    logic [ZW-1:0]          z_q, z_n;
    logic                   ov_q, ov_n;
    logic                   ir_q, ir_n;

    logic signed [EW-1:0]   in_e_x;
    logic                   round_up;
    logic [MAN_W+1:0]       rsum;
    logic [EXP_W-1:0]       exp_field;

    assign in_e_x    = {bus.in_e[EXP_W+1], bus.in_e};
    // Round-to-nearest-even on the G/R/S bits; rsum carries into its top bit on overflow.
    assign round_up  = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    assign rsum      = {1'b0, m_q[MW-1:3]} + (MAN_W+2)'(round_up);
    assign exp_field = EXP_W'(e_q + EMAX);

    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        e_n     = e_q;
        m_n     = m_q;
        cnt_n   = cnt_q;
        z_n     = z_q;
        ov_n    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    s_n   = bus.in_s;
                    e_n   = in_e_x;
                    m_n   = bus.in_m;
                    cnt_n = '0;
                    if (bus.in_m == '0)     state_n = PACK;
                    else if (in_e_x < EMIN) state_n = DENORM;
                    else                    state_n = NORM;
                end
            end
            NORM: begin
                if (!m_q[MW-1] && (e_q > EMIN)) begin
                    m_n = {m_q[MW-2:0], 1'b0};
                    e_n = e_q - E_ONE;
                end else begin
                    state_n = ROUND;
                end
            end
            DENORM: begin
                // Right shift keeps everything lost ORed into bit 0; capped at MW shifts.
                if ((e_q < EMIN) && (cnt_q != SHIFT_MAX)) begin
                    m_n   = {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
                    e_n   = e_q + E_ONE;
                    cnt_n = cnt_q + CW'(1);
                end else begin
                    e_n     = EMIN;
                    state_n = ROUND;
                end
            end
            ROUND: begin
                if (rsum[MAN_W+1]) begin
                    m_n = {rsum[MAN_W+1:1], 3'b000};
                    e_n = e_q + E_ONE;
                end else begin
                    m_n = {rsum[MAN_W:0], 3'b000};
                end
                state_n = PACK;
            end
            PACK: begin
                if (m_q == '0)
                    z_n = {s_q, (ZW-1)'(0)};
                else if (e_q > EMAX)
                    z_n = {s_q, {EXP_W{1'b1}}, MAN_W'(0)};
                else if (m_q[MW-1])
                    z_n = {s_q, exp_field, m_q[MW-2:3]};
                else
                    z_n = {s_q, EXP_W'(0), m_q[MW-2:3]};
                ov_n    = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    ov_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        ir_n = (state_n == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            e_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            ov_q    <= 1'b0;
            ir_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            s_q     <= s_n;
            e_q     <= e_n;
            m_q     <= m_n;
            cnt_q   <= cnt_n;
            z_q     <= z_n;
            ov_q    <= ov_n;
            ir_q    <= ir_n;
        end
    end

    assign bus.in_ready  = ir_q;
    assign bus.out_valid = ov_q;
    assign bus.out_z     = z_q;
endmodule

// File: tb/tb_double_pack.sv
// Bench for double_pack: directed corner cases plus randomized operands against an
// exact arithmetic model of round-to-nearest-even packing.
module tb_double_pack;
    localparam int unsigned EXP_W = 11;
    localparam int unsigned MAN_W = 52;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    double_pack_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    double_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(1023)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Exact value m * 2^(e-55), rounded to the double grid (lsb weight 2^(max(E,-1022)-52)).
    function automatic logic [63:0] ref_pack(input logic s, input int e, input logic [55:0] m);
        int p, ex, q, sh;
        logic [63:0] mm, kept, mask;
        logic half, rest;
        if (m == 56'h0) return {s, 63'h0};
        p = 55;
        while (m[p] == 1'b0) p--;
        ex = e - 55 + p;
        q  = ((ex > -1022) ? ex : -1022) - 52;
        sh = q - (e - 55);
        mm = {8'h0, m};
        if (sh <= 0) begin
            kept = mm << (-sh);
            half = 1'b0;
            rest = 1'b0;
        end else if (sh > 60) begin
            kept = 64'h0;
            half = 1'b0;
            rest = 1'b1;
        end else begin
            kept = mm >> sh;
            half = mm[sh-1];
            mask = (64'd1 << (sh - 1)) - 64'd1;
            rest = (mm & mask) != 64'h0;
        end
        if (half && (rest || kept[0])) kept = kept + 64'd1;
        if (kept[53]) begin
            kept = kept >> 1;
            q    = q + 1;
        end
        if (kept == 64'h0) return {s, 63'h0};
        if (q + 52 > 1023) return {s, 11'h7FF, 52'h0};
        if (!kept[52]) return {s, 11'h0, kept[51:0]};
        return {s, 11'(q + 52 + 1023), kept[51:0]};
    endfunction

    task automatic gen_op(output logic s, output int e, output logic [55:0] m);
        logic [63:0] raw;
        int cat;
        raw = {$urandom, $urandom};
        s   = raw[63];
        m   = raw[55:0] >> $urandom_range(0, 58);
        cat = int'($urandom_range(0, 4));
        case (cat)
            0: e = int'($urandom_range(0, 120)) - 60;
            1: e = int'($urandom_range(0, 110)) - 1110;
            2: e = int'($urandom_range(0, 80)) + 980;
            3: e = int'($urandom_range(0, 8191)) - 4096;
            default: begin
                e = int'($urandom_range(0, 60)) - 30;
                m = (m & ~56'h7) | 56'h4;
            end
        endcase
    endtask

    // Present an operand, wait for acceptance, then wait for out_valid (bounded).
    task automatic drive_op(input logic s, input int e, input logic [55:0] m, input bit junk,
                            output logic [63:0] z, output int lat, output bit to);
        int n;
        bus.in_s     = s;
        bus.in_e     = 13'(e);
        bus.in_m     = m;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        if (junk) begin
            bus.in_s = ~s;
            bus.in_e = 13'($urandom);
            bus.in_m = 56'({$urandom, $urandom});
        end else begin
            bus.in_valid = 1'b0;
        end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        to = (n >= 200) || (bus.out_valid !== 1'b1);
        z  = bus.out_z;
        bus.in_valid = 1'b0;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out_z !== 64'h0) $display("FAIL reset_out_z got %h want 0", bus.out_z); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); else passed++;
    endtask

    task automatic test_directed();
        logic        ds[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          de[10] = '{0, 52, 0, 0, 1023, 1024, -1023, 0, -1100, -1023};
        logic [55:0] dm[10] = '{56'h80000000000000, 56'h00000000000008, 56'h80000000000004,
                                56'h8000000000000C, 56'hFFFFFFFFFFFFFC, 56'h80000000000000,
                                56'h80000000000000, 56'h00000000000000, 56'h80000000000000,
                                56'hFFFFFFFFFFFFFF};
        logic [63:0] dz[10] = '{64'h3FF0000000000000, 64'hBFF0000000000000, 64'h3FF0000000000000,
                                64'h3FF0000000000002, 64'h7FF0000000000000, 64'h7FF0000000000000,
                                64'h0008000000000000, 64'h8000000000000000, 64'h0000000000000000,
                                64'h0010000000000000};
        int          dl[10] = '{3, 55, 3, 3, 3, 3, 4, -1, 59, 4};
        logic [63:0] z;
        int          lat;
        bit          to;
        for (int i = 0; i < 10; i++) begin
            drive_op(ds[i], de[i], dm[i], 1'b0, z, lat, to);
            total++;
            if (to || z !== dz[i]) $display("FAIL directed[%0d] out_z got %h want %h timeout=%0d", i, z, dz[i], to);
            else passed++;
            if (dl[i] >= 0) begin
                total++;
                if (lat != dl[i]) $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, dl[i]);
                else passed++;
            end
            take_result();
            total++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
                $display("FAIL directed_handshake[%0d] out_valid=%b in_ready=%b want 0/1", i, bus.out_valid, bus.in_ready);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] z;
        int          lat;
        bit          to;
        drive_op(1'b0, 0, 56'h80000000000000, 1'b1, z, lat, to);
        total++; if (to || z !== 64'h3FF0000000000000) $display("FAIL bp_result got %h want 3ff0000000000000", z); else passed++;
        bus.in_valid = 1'b1;
        bus.in_s     = 1'b1;
        bus.in_e     = 13'(0);
        bus.in_m     = 56'h8000000000000C;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++; if (bus.out_z !== 64'h3FF0000000000000) $display("FAIL bp_hold_z[%0d] got %h want 3ff0000000000000", c, bus.out_z); else passed++;
            total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b want 1", c, bus.out_valid); else passed++;
            total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_hold_in_ready[%0d] got %b want 0", c, bus.in_ready); else passed++;
        end
        // in_valid stays high through the handshake edge; it must not be accepted there.
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); else passed++;
        repeat (6) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_queue got out_valid=%b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] z;
        int          lat;
        bit          to;
        bus.in_s     = 1'b1;
        bus.in_e     = 13'(52);
        bus.in_m     = 56'h00000000000008;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL mid_busy_in_ready got %b want 0", bus.in_ready); else passed++;
        rst = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_reset_in_ready got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_reset_out_valid got %b want 0", bus.out_valid); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        drive_op(1'b0, 0, 56'h8000000000000C, 1'b0, z, lat, to);
        total++; if (to || z !== 64'h3FF0000000000002) $display("FAIL mid_recover got %h want 3ff0000000000002", z); else passed++;
        total++; if (lat != 3) $display("FAIL mid_recover_latency got %0d want 3", lat); else passed++;
        take_result();
    endtask

    task automatic test_random();
        logic        s;
        int          e;
        logic [55:0] m;
        logic [63:0] z, exp_z;
        int          lat;
        bit          to;
        for (int i = 0; i < 150; i++) begin
            gen_op(s, e, m);
            exp_z = ref_pack(s, e, m);
            drive_op(s, e, m, 1'b0, z, lat, to);
            total++;
            if (to || z !== exp_z) $display("FAIL random[%0d] s=%b e=%0d m=%h got %h want %h", i, s, e, m, z, exp_z);
            else passed++;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            take_result();
        end
    endtask

    task automatic test_back_to_back();
        logic        s;
        int          e;
        logic [55:0] m;
        logic [63:0] z, exp_z;
        int          lat;
        bit          to;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            gen_op(s, e, m);
            exp_z = ref_pack(s, e, m);
            drive_op(s, e, m, 1'b1, z, lat, to);
            total++;
            if (to || z !== exp_z) $display("FAIL b2b[%0d] s=%b e=%0d m=%h got %h want %h", i, s, e, m, z, exp_z);
            else passed++;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got out_valid=%b want 0", bus.out_valid); else passed++;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_s      = 1'b0;
        bus.in_e      = '0;
        bus.in_m      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
